// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: byte FIFO feeding the UART transmitter.
// First-word-fall-through read, sticky overflow, flush.
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         enq_data,
    input  logic                     enq_valid,
    output logic                     enq_ready,
    output logic [WIDTH-1:0]         deq_data,
    output logic                     deq_valid,
    input  logic                     deq_ready,
    input  logic                     flush,
    input  logic                     clear_overflow,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_overflow;

    logic             w_full;
    logic             w_empty;
    logic             w_enq;
    logic             w_deq;

    // Status is derived from the count register only, so the
    // ready/valid outputs never depend on the opposite handshake.
    always_comb begin
        w_full  = (r_count == CW'(DEPTH));
        w_empty = (r_count == '0);
        w_enq   = enq_valid & ~w_full;
        w_deq   = deq_ready & ~w_empty;
    end

    // Storage: written on an accepted enqueue; never reset.
    always_ff @(posedge clk) begin
        if (w_enq && !flush && !reset) begin
            r_mem[r_wr_ptr] <= enq_data;
        end
    end

    // Pointers and occupancy; flush discards same-cycle traffic.
    always_ff @(posedge clk) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + CW'(1);
            end else if (w_deq && !w_enq) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

    // Sticky overflow: clear beats a simultaneous set; flush leaves it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (clear_overflow) begin
            r_overflow <= 1'b0;
        end else if (enq_valid && w_full) begin
            r_overflow <= 1'b1;
        end
    end

    // Output wiring.
    always_comb begin
        enq_ready = ~w_full;
        deq_valid = ~w_empty;
        deq_data  = r_mem[r_rd_ptr];
        count     = r_count;
        full      = w_full;
        empty     = w_empty;
        overflow  = r_overflow;
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench with a queue-based model.
// Directed plan sequences followed by randomized traffic.
module tb_uart_tx_fifo;

    localparam int DEPTH = 8;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [WIDTH-1:0] enq_data = '0;
    logic             enq_valid = 1'b0;
    logic             enq_ready;
    logic [WIDTH-1:0] deq_data;
    logic             deq_valid;
    logic             deq_ready = 1'b0;
    logic             flush = 1'b0;
    logic             clear_overflow = 1'b0;
    logic [3:0]       count;
    logic             full;
    logic             empty;
    logic             overflow;

    int checks = 0;
    int failures = 0;

    logic [WIDTH-1:0] sb_q[$];
    bit               m_ovf = 1'b0;
    logic [7:0]       seq_byte;

    uart_tx_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .enq_data       (enq_data),
        .enq_valid      (enq_valid),
        .enq_ready      (enq_ready),
        .deq_data       (deq_data),
        .deq_valid      (deq_valid),
        .deq_ready      (deq_ready),
        .flush          (flush),
        .clear_overflow (clear_overflow),
        .count          (count),
        .full           (full),
        .empty          (empty),
        .overflow       (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // Monitor: just before each rising edge, a handshake pops the
    // oldest expected byte and compares it with the head data.
    always begin
        @(negedge clk);
        #4;
        if (!reset && !flush && deq_valid && deq_ready) begin
            if (sb_q.size() == 0) begin
                chk("deq_unexpected", 1, 0);
            end else begin
                chk("deq_data", int'(deq_data), int'(sb_q.pop_front()));
            end
        end
    end

    // One cycle: check status against the model, then drive inputs
    // and record what the model says the FIFO accepts at this edge.
    task automatic cyc(input logic ev, input logic [7:0] d,
                       input logic dr, input logic fl,
                       input logic cl, input logic rs);
        int n;
        @(negedge clk);
        n = sb_q.size();
        chk("count", int'(count), n);
        chk("full", int'(full), int'(n == DEPTH));
        chk("empty", int'(empty), int'(n == 0));
        chk("enq_ready", int'(enq_ready), int'(n != DEPTH));
        chk("deq_valid", int'(deq_valid), int'(n != 0));
        chk("overflow", int'(overflow), int'(m_ovf));
        enq_valid      = ev;
        enq_data       = d;
        deq_ready      = dr;
        flush          = fl;
        clear_overflow = cl;
        reset          = rs;
        if (rs) begin
            sb_q.delete();
            m_ovf = 1'b0;
        end else begin
            if (cl) m_ovf = 1'b0;
            else if (ev && n == DEPTH) m_ovf = 1'b1;
            if (fl) sb_q.delete();
            else if (ev && n < DEPTH) sb_q.push_back(d);
        end
    endtask

    initial begin
        // Reset and idle.
        cyc(0, 8'h00, 0, 0, 0, 1);
        cyc(0, 8'h00, 0, 0, 0, 1);
        cyc(0, 8'h00, 0, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 0, 0);

        // Three bytes in, then drained in order.
        cyc(1, 8'h41, 0, 0, 0, 0);
        cyc(1, 8'h42, 0, 0, 0, 0);
        cyc(1, 8'h43, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 8'h00, 1, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 0, 0);

        // Fill, overflow attempt, drain, clear overflow.
        for (int i = 0; i < DEPTH; i++) cyc(1, 8'(i), 0, 0, 0, 0);
        cyc(1, 8'hFF, 0, 0, 0, 0);
        cyc(1, 8'hFF, 1, 0, 0, 0);
        for (int i = 0; i < DEPTH; i++) cyc(0, 8'h00, 1, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 1, 0);
        cyc(0, 8'h00, 0, 0, 0, 0);

        // Steady state at count 4 with wrap-around.
        seq_byte = 8'h10;
        for (int i = 0; i < 4; i++) begin
            cyc(1, seq_byte, 0, 0, 0, 0);
            seq_byte++;
        end
        for (int i = 0; i < 20; i++) begin
            cyc(1, seq_byte, 1, 0, 0, 0);
            seq_byte++;
        end
        for (int i = 0; i < 4; i++) cyc(0, 8'h00, 1, 0, 0, 0);

        // Flush at count 5 with traffic in the same cycle.
        for (int i = 0; i < 5; i++) cyc(1, 8'(8'h60 + i), 0, 0, 0, 0);
        cyc(1, 8'hEE, 1, 1, 0, 0);
        cyc(1, 8'h5A, 0, 0, 0, 0);
        cyc(0, 8'h00, 1, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 0, 0);

        // Randomized traffic including flush, clear and reset.
        for (int i = 0; i < 3000; i++) begin
            int r;
            r = int'($urandom_range(0, 999));
            cyc(logic'($urandom_range(0, 99) < 60),
                8'($urandom),
                logic'($urandom_range(0, 99) < 45),
                logic'(r < 15),
                logic'(r >= 15 && r < 45),
                logic'(r >= 990));
        end

        // Drain and final idle check.
        for (int i = 0; i < DEPTH + 2; i++) cyc(0, 8'h00, 1, 0, 0, 0);
        cyc(0, 8'h00, 0, 0, 0, 0);
        chk("sb_empty", sb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
